// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the BCD calculator core
package calc_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;
    localparam int DIGIT_W            = 4;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_CALC   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(9)) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - single BCD digit adder/subtractor with carry/borrow
module bcd_digit_addsub
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    localparam logic [DIGIT_W:0] TEN = (DIGIT_W+1)'(10);

    logic [DIGIT_W:0] t;

    always_comb begin
        t    = '0;
        cout = 1'b0;
        if (sub) begin
            // A negative difference shows up as the extra top bit; fold back by adding ten.
            t = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, cin};
            if (t[DIGIT_W]) begin
                cout = 1'b1;
                t    = t + TEN;
            end
        end else begin
            t = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
            if (t >= TEN) begin
                cout = 1'b1;
                t    = t - TEN;
            end
        end
        sum = t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/calculator_core.sv
// rtl/calculator_core.sv - BCD calculator: digit entry, digit-serial add/sub, result display
module calculator_core
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          button_clr,
    input  logic                          button_ent,
    input  logic                          button_add,
    input  logic                          button_sub,
    input  logic                          slider_1,
    input  logic                          slider_2,
    input  logic                          slider_3,
    input  logic                          slider_4,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
    output logic [1:0]                    op_pending,
    output logic                          overflow,
    output logic                          busy
);

    localparam int W           = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NUM_SLIDERS = (NUM_DIGITS < 4) ? NUM_DIGITS : 4;

    state_t             state_q, state_n;
    op_t                op_q, op_n, new_op;
    logic [W-1:0]       acc_q, acc_n;
    logic [W-1:0]       operand_q, operand_n;
    logic [W-1:0]       res_q, res_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               carry_q, carry_n;
    logic               ovf_q, ovf_n;
    logic [3:0]         btn_prev, sld_prev;

    logic [3:0]         btn_cur, sld_cur, btn_ev, sld_ev;
    logic               clr_ev, ent_ev, add_ev, sub_ev, any_btn;
    logic [DIGIT_W-1:0] dig_a, dig_b, dig_sum;
    logic               dig_cout;

    assign btn_cur = {button_clr, button_ent, button_add, button_sub};
    assign sld_cur = {slider_4, slider_3, slider_2, slider_1};
    assign btn_ev  = btn_cur & ~btn_prev;
    assign sld_ev  = sld_cur ^ sld_prev;

    // Priority CLR > ENT > ADD > SUB; losers in the same cycle are dropped.
    assign clr_ev  = btn_ev[3];
    assign ent_ev  = btn_ev[2] & ~btn_ev[3];
    assign add_ev  = btn_ev[1] & ~|btn_ev[3:2];
    assign sub_ev  = btn_ev[0] & ~|btn_ev[3:1];
    assign any_btn = |btn_ev;
    assign new_op  = add_ev ? OP_ADD : OP_SUB;

    assign dig_a = acc_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dig_b = operand_q[idx_q*DIGIT_W +: DIGIT_W];

    bcd_digit_addsub u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sub  (op_q == OP_SUB),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge clk) begin
        btn_prev <= btn_cur;
        sld_prev <= sld_cur;
        if (reset) begin
            state_q   <= ST_ENTRY;
            op_q      <= OP_NONE;
            acc_q     <= '0;
            operand_q <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            acc_q     <= acc_n;
            operand_q <= operand_n;
            res_q     <= res_n;
            idx_q     <= idx_n;
            carry_q   <= carry_n;
            ovf_q     <= ovf_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        op_n      = op_q;
        acc_n     = acc_q;
        operand_n = operand_q;
        res_n     = res_q;
        idx_n     = idx_q;
        carry_n   = carry_q;
        ovf_n     = ovf_q;

        if (clr_ev) begin
            state_n   = ST_ENTRY;
            op_n      = OP_NONE;
            acc_n     = '0;
            operand_n = '0;
            idx_n     = '0;
            carry_n   = 1'b0;
            ovf_n     = 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (ent_ev) begin
                        if (op_q != OP_NONE) begin
                            state_n = ST_CALC;
                            ovf_n   = 1'b0;
                            carry_n = 1'b0;
                            idx_n   = '0;
                        end
                    end else if (add_ev || sub_ev) begin
                        if (op_q == OP_NONE) begin
                            acc_n     = operand_q;
                            operand_n = '0;
                        end
                        op_n = new_op;
                    end else if (!any_btn) begin
                        for (int i = 0; i < NUM_SLIDERS; i++) begin
                            if (sld_ev[i])
                                operand_n[i*DIGIT_W +: DIGIT_W] =
                                    bcd_inc(operand_q[i*DIGIT_W +: DIGIT_W]);
                        end
                    end
                end
                ST_CALC: begin
                    res_n[idx_q*DIGIT_W +: DIGIT_W] = dig_sum;
                    carry_n = dig_cout;
                    idx_n   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        acc_n     = res_n;
                        ovf_n     = dig_cout;
                        op_n      = OP_NONE;
                        operand_n = '0;
                        carry_n   = 1'b0;
                        idx_n     = '0;
                        state_n   = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (add_ev || sub_ev) begin
                        op_n      = new_op;
                        operand_n = '0;
                        state_n   = ST_ENTRY;
                    end else if (!any_btn && (|sld_ev)) begin
                        // A fresh entry starts from zero with each toggled digit at one.
                        operand_n = '0;
                        for (int i = 0; i < NUM_SLIDERS; i++) begin
                            if (sld_ev[i])
                                operand_n[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(1);
                        end
                        op_n    = OP_NONE;
                        state_n = ST_ENTRY;
                    end
                end
                default: state_n = ST_ENTRY;
            endcase
        end
    end

    assign bcd_out    = (state_q == ST_RESULT) ? acc_q : operand_q;
    assign op_pending = op_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q == ST_CALC);

endmodule

// File: tb/tb_calculator_core.sv
// tb/tb_calculator_core.sv - self-checking bench for calculator_core
module tb_calculator_core;

    localparam int N   = 4;
    localparam int MOD = 10000;

    logic          clk, reset;
    logic          button_clr, button_ent, button_add, button_sub;
    logic [3:0]    sld;
    logic [4*N-1:0] bcd_out;
    logic [1:0]    op_pending;
    logic          overflow, busy;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    calculator_core #(.NUM_DIGITS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .button_clr (button_clr),
        .button_ent (button_ent),
        .button_add (button_add),
        .button_sub (button_sub),
        .slider_1   (sld[0]),
        .slider_2   (sld[1]),
        .slider_3   (sld[2]),
        .slider_4   (sld[3]),
        .bcd_out    (bcd_out),
        .op_pending (op_pending),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pw(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((v / pw(k)) % 10);
        return r;
    endfunction

    // Behavioural model: whole-number arithmetic, result computed at ENT and released N cycles later.
    int m_state = 0;  // 0 entry, 1 calc, 2 result
    int m_acc = 0, m_opd = 0, m_op = 0, m_ovf = 0, m_cnt = 0, m_res = 0, m_res_ovf = 0;
    logic [3:0] m_bprev = '0, m_sprev = '0;

    always @(posedge clk) begin
        logic [3:0] bcur, bev, sev;
        int d, s;
        bcur = {button_clr, button_ent, button_add, button_sub};
        if (reset) begin
            m_state = 0; m_acc = 0; m_opd = 0; m_op = 0; m_ovf = 0; m_cnt = 0;
            m_bprev = bcur; m_sprev = sld;
        end else begin
            bev = bcur & ~m_bprev;
            sev = sld ^ m_sprev;
            m_bprev = bcur; m_sprev = sld;
            if (bev[3]) begin
                m_state = 0; m_acc = 0; m_opd = 0; m_op = 0; m_ovf = 0; m_cnt = 0;
            end else if (m_state == 1) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_acc = m_res; m_ovf = m_res_ovf; m_op = 0; m_opd = 0; m_state = 2;
                end
            end else if (bev[2]) begin
                if (m_state == 0 && m_op != 0) begin
                    if (m_op == 1) begin
                        s = m_acc + m_opd;
                        m_res = s % MOD; m_res_ovf = (s >= MOD);
                    end else begin
                        s = m_acc - m_opd;
                        m_res_ovf = (s < 0); m_res = (s < 0) ? s + MOD : s;
                    end
                    m_state = 1; m_cnt = N; m_ovf = 0;
                end
            end else if (bev[1] || bev[0]) begin
                if (m_state == 0) begin
                    if (m_op == 0) begin m_acc = m_opd; m_opd = 0; end
                    m_op = bev[1] ? 1 : 2;
                end else begin
                    m_op = bev[1] ? 1 : 2; m_opd = 0; m_state = 0;
                end
            end else if (sev != 0) begin
                if (m_state == 0) begin
                    for (int k = 0; k < N; k++) if (sev[k]) begin
                        d = (m_opd / pw(k)) % 10;
                        m_opd = m_opd + ((d + 1) % 10 - d) * pw(k);
                    end
                end else begin
                    m_opd = 0;
                    for (int k = 0; k < N; k++) if (sev[k]) m_opd = m_opd + pw(k);
                    m_op = 0; m_state = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_bcd_out", 32'(bcd_out), 32'(to_bcd(m_state == 2 ? m_acc : m_opd)));
            chk("model_busy", 32'(busy), 32'(m_state == 1));
            chk("model_op", 32'(op_pending), 32'(m_op));
            chk("model_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        case (b)
            0: button_clr = 1; 1: button_ent = 1; 2: button_add = 1; default: button_sub = 1;
        endcase
        tick();
        button_clr = 0; button_ent = 0; button_add = 0; button_sub = 0;
        tick();
    endtask

    task automatic toggle(input int k);
        sld[k] = ~sld[k];
        tick();
    endtask

    task automatic enter_num(input int v);
        for (int k = 0; k < N; k++) repeat ((v / pw(k)) % 10) toggle(k);
    endtask

    task automatic calc(output int cycles);
        button_ent = 1;
        tick();
        button_ent = 0;
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input int a, input int b, input int opb);
        int c;
        press(0);
        enter_num(a);
        press(opb);
        enter_num(b);
        calc(c);
    endtask

    int cyc;

    initial begin
        reset = 1; button_clr = 0; button_ent = 0; button_add = 0; button_sub = 0; sld = '0;
        tick();
        checking = 1;
        tick();
        reset = 0;
        tick();
        chk("reset_bcd", 32'(bcd_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_op", 32'(op_pending), 32'h0);

        repeat (3) toggle(0);
        toggle(2);
        chk("entry_0103", 32'(bcd_out), 32'h0103);

        press(0);
        enter_num(125);
        press(2);
        enter_num(98);
        calc(cyc);
        chk("add_busy_cycles", 32'(cyc), 32'd4);
        chk("add_0223", 32'(bcd_out), 32'h0223);
        chk("add_ovf", 32'(overflow), 32'h0);
        chk("model_pin_add", 32'(to_bcd(m_acc)), 32'h0223);

        run_op(9999, 1, 2);
        chk("wrap_0000", 32'(bcd_out), 32'h0000);
        chk("wrap_ovf", 32'(overflow), 32'h1);

        run_op(5, 7, 3);
        chk("borrow_9998", 32'(bcd_out), 32'h9998);
        chk("borrow_ovf", 32'(overflow), 32'h1);
        chk("model_pin_sub", 32'(to_bcd(m_acc)), 32'h9998);

        press(0);
        enter_num(125);
        press(2);
        enter_num(98);
        button_ent = 1;
        tick();
        button_ent = 0;
        tick();
        button_clr = 1;
        tick();
        chk("abort_bcd", 32'(bcd_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_op", 32'(op_pending), 32'h0);
        chk("abort_ovf", 32'(overflow), 32'h0);
        button_clr = 0;
        tick();

        sld[1] = 1;
        reset = 1;
        tick(); tick();
        reset = 0;
        tick(); tick();
        chk("held_slider_no_inc", 32'(bcd_out), 32'h0);
        sld[0] = ~sld[0];
        button_add = 1;
        tick();
        button_add = 0;
        tick();
        chk("slider_with_btn_dropped", 32'(bcd_out), 32'h0);
        chk("slider_with_btn_op", 32'(op_pending), 32'h1);
        press(0);
        toggle(0);
        press(1);
        chk("ent_none_busy", 32'(busy), 32'h0);
        chk("ent_none_bcd", 32'(bcd_out), 32'h0001);

        run_op(10, 5, 2);
        chk("chain_0015", 32'(bcd_out), 32'h0015);
        press(3);
        enter_num(3);
        calc(cyc);
        chk("chain_0012", 32'(bcd_out), 32'h0012);
        chk("chain_ovf", 32'(overflow), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) reset = 1;
            else reset = 0;
            if ($urandom_range(0, 99) < 2) button_clr = ~button_clr;
            if ($urandom_range(0, 99) < 12) button_ent = ~button_ent;
            if ($urandom_range(0, 99) < 10) button_add = ~button_add;
            if ($urandom_range(0, 99) < 10) button_sub = ~button_sub;
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 99) < 10) sld[k] = ~sld[k];
            tick();
        end
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_core.md
CALCULATOR_CORE -- requirements
Module: calculator_core

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, the number of BCD digits in the operand, accumulator and display.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports button_clr, button_ent, button_add and button_sub, each input, 1, a debounced, synchronized level from the input stage.
REQ-005 SHALL have ports slider_1, slider_2, slider_3 and slider_4, each input, 1, debounced, synchronized switch levels for digits 0 to 3 (1er to 1000er).
REQ-006 SHALL have port bcd_out, output, 4*NUM_DIGITS, the BCD display value; digit 0 is in bits [3:0].
REQ-007 SHALL have port op_pending, output, 2, the current op_t value: NONE=0, ADD=1, SUB=2.
REQ-008 SHALL have port overflow, output, 1, the carry-out or borrow of the last calculation.
REQ-009 SHALL have port busy, output, 1, high while the state is CALC.

Function
REQ-010 SHALL register the previous level of each input and define events as follows:
- Button event: current & ~prev.
- Slider event: current ^ prev (either edge).
- Events are combinational and usable in the same cycle.
REQ-011 SHALL implement states ENTRY, CALC and RESULT; only these transitions exist: ENTRY->CALC, CALC->RESULT, RESULT->ENTRY, and any state->ENTRY on CLR.
REQ-012 SHALL apply button-event priority CLR > ENT > ADD > SUB; lower-priority button events in the same cycle are discarded.
REQ-013 SHALL discard all slider events in a cycle that has any button event.
REQ-014 SHALL apply all slider events in the same cycle together.
REQ-015 SHALL, on a CLR event in any state (including mid-CALC), do the following next cycle:
- clear accumulator, operand, op and overflow;
- enter ENTRY.
REQ-016 SHALL, in ENTRY, increment operand digit k-1 modulo 10 (9 wraps to 0) for each slider_k event.
REQ-017 SHALL, in ENTRY on an ADD or SUB event, do the following:
- if op is NONE: load accumulator from operand, clear operand, set op;
- otherwise: replace op only.
REQ-018 SHALL, in ENTRY on an ENT event, enter CALC and clear overflow if op is not NONE; if op is NONE, the event is ignored.
REQ-019 SHALL, in CALC, process one digit per cycle, digit 0 first, with a registered carry/borrow (initially 0), for exactly NUM_DIGITS cycles.
REQ-020 SHALL, on the last CALC cycle, do all of the following:
- write the result to the accumulator modulo 10^NUM_DIGITS;
- set overflow to the final carry or borrow;
- set op to NONE and clear operand;
- enter RESULT.
REQ-021 SHALL produce SUB results as the ten's complement when the result is negative (for example 0005-0007 gives 9998), with overflow=1.
REQ-022 SHALL ignore all events except CLR during CALC; prev registers keep updating.
REQ-023 SHALL have a latency such that a button_ent first sampled high at clock edge t enters CALC at t, and the result appears on bcd_out after edge t+NUM_DIGITS.
REQ-024 SHALL, in RESULT, handle events as follows:
- ADD or SUB event: set op, keep accumulator (chaining), clear operand, enter ENTRY.
- slider event: enter ENTRY with operand = 0 plus the toggled digits set to 1, and set op to NONE.
- ENT event: ignored.
REQ-025 SHALL drive bcd_out as follows: ENTRY shows the operand, CALC holds the operand, RESULT shows the accumulator.
REQ-026 SHALL keep every operand and accumulator digit in 0..9 at all times.

Reset
REQ-027 SHALL, on reset, set state ENTRY, accumulator 0, operand 0, op NONE, carry 0, bcd_out 0, overflow 0 and busy 0.
REQ-028 SHALL, during reset, load the prev registers with the current input levels, so that an input held high across reset generates no event.

Structure
REQ-029 SHALL place op_t, state_t, NUM_DIGITS_DEFAULT and the BCD digit width in a shared package calc_pkg.
REQ-030 SHALL instantiate exactly one sub-module, bcd_digit_addsub: inputs a, b, cin, sub; outputs sum and cout; combinational, single digit.

Verification
REQ-031 SHALL verify entry: after reset, toggle slider_1 three times and slider_3 once; bcd_out must be 0x0103.
REQ-032 SHALL verify addition: enter 0125, ADD, enter 0098, ENT; busy must be high exactly 4 cycles, then bcd_out=0x0223 and overflow=0.
REQ-033 SHALL verify wrap and borrow:
- 9999+0001 gives 0x0000 with overflow=1;
- 0005-0007 gives 0x9998 with overflow=1.
REQ-034 SHALL verify abort: CLR in the second CALC cycle; next cycle bcd_out=0, busy=0, op_pending=0 and overflow=0.
REQ-035 SHALL verify event filtering:
- slider_2 held high across reset gives no increment;
- slider_1 toggled in the same cycle as a button_add event is discarded;
- ENT with op NONE leaves the state unchanged.
REQ-036 SHALL verify chaining: 0010+0005 ENT gives 0x0015; then SUB, enter 0003, ENT gives 0x0012.
